// File: rtl/triangle_bbox_scanner_pkg.sv
// Shared definitions for the triangle bounding-box scanner.
//   DEF_COORD_W : default coordinate width (unsigned integer pixels)
//   DEF_WIDTH   : default screen width  (x clamped to [0, WIDTH-1])
//   DEF_HEIGHT  : default screen height (y clamped to [0, HEIGHT-1])
//   state_t     : scanner FSM states
package triangle_bbox_scanner_pkg;

    localparam int unsigned DEF_COORD_W = 16;
    localparam int unsigned DEF_WIDTH   = 640;
    localparam int unsigned DEF_HEIGHT  = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BBOX = 2'd1,
        SCAN = 2'd2
    } state_t;

endpackage

// File: rtl/triangle_bbox_scanner_bbox_minmax3.sv
// Combinational minimum and maximum of three unsigned values.
//   a, b, c : W-bit unsigned inputs
//   mn      : smallest of a, b, c
//   mx      : largest of a, b, c
module bbox_minmax3 #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] mn,
    output logic [W-1:0] mx
);

    logic [W-1:0] mn_ab;
    logic [W-1:0] mx_ab;

    always_comb begin
        mn_ab = (a < b) ? a : b;
        mx_ab = (a > b) ? a : b;
        mn    = (mn_ab < c) ? mn_ab : c;
        mx    = (mx_ab > c) ? mx_ab : c;
    end

endmodule

// File: rtl/triangle_bbox_scanner.sv
// Triangle bounding-box scanner: accepts one triangle, clamps its bounding box
// to the screen and walks it in raster order (x fastest), one candidate pixel
// per nd/ds_rfd transfer, with the latched vertices held beside every pixel.
//   clk, rst        : clock, synchronous active-high reset
//   tri_nd, tri_rfd : triangle handshake (accept when both high)
//   t1_x..t3_y      : incoming vertices, sampled on accept
//   nd, ds_rfd      : pixel handshake (transfer when both high)
//   v1_x..v3_y      : latched vertices
//   p_x, p_y        : current pixel
//   p_last          : current pixel is the last of the triangle
//   done            : one-cycle pulse after last transfer or empty-box reject
//   busy            : scanner not idle
module triangle_bbox_scanner
    import triangle_bbox_scanner_pkg::*;
#(
    parameter int unsigned COORD_W = DEF_COORD_W,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned HEIGHT  = DEF_HEIGHT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tri_nd,
    output logic               tri_rfd,
    input  logic [COORD_W-1:0] t1_x,
    input  logic [COORD_W-1:0] t1_y,
    input  logic [COORD_W-1:0] t2_x,
    input  logic [COORD_W-1:0] t2_y,
    input  logic [COORD_W-1:0] t3_x,
    input  logic [COORD_W-1:0] t3_y,
    output logic               nd,
    input  logic               ds_rfd,
    output logic [COORD_W-1:0] v1_x,
    output logic [COORD_W-1:0] v1_y,
    output logic [COORD_W-1:0] v2_x,
    output logic [COORD_W-1:0] v2_y,
    output logic [COORD_W-1:0] v3_x,
    output logic [COORD_W-1:0] v3_y,
    output logic [COORD_W-1:0] p_x,
    output logic [COORD_W-1:0] p_y,
    output logic               p_last,
    output logic               done,
    output logic               busy
);

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

    state_t             state;
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymax;

    logic [COORD_W-1:0] bx_min;
    logic [COORD_W-1:0] bx_max;
    logic [COORD_W-1:0] by_min;
    logic [COORD_W-1:0] by_max;
    logic [COORD_W-1:0] bx_max_c;
    logic [COORD_W-1:0] by_max_c;
    logic               box_empty;
    logic               xfer;

    bbox_minmax3 #(.W(COORD_W)) u_x (
        .a  (v1_x),
        .b  (v2_x),
        .c  (v3_x),
        .mn (bx_min),
        .mx (bx_max)
    );

    bbox_minmax3 #(.W(COORD_W)) u_y (
        .a  (v1_y),
        .b  (v2_y),
        .c  (v3_y),
        .mn (by_min),
        .mx (by_max)
    );

    // Only the upper bound needs clamping; a min beyond the screen edge means
    // the whole box is off screen.
    always_comb begin
        bx_max_c  = (bx_max > X_LIM) ? X_LIM : bx_max;
        by_max_c  = (by_max > Y_LIM) ? Y_LIM : by_max;
        box_empty = (bx_min > X_LIM) || (by_min > Y_LIM);
        xfer      = nd && ds_rfd;
    end

    // p_last is precomputed for the pixel being loaded, so it is valid in the
    // same cycle as the pixel it qualifies.
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state   <= IDLE;
            tri_rfd <= 1'b1;
            nd      <= 1'b0;
            p_last  <= 1'b0;
            busy    <= 1'b0;
            v1_x    <= '0;
            v1_y    <= '0;
            v2_x    <= '0;
            v2_y    <= '0;
            v3_x    <= '0;
            v3_y    <= '0;
            p_x     <= '0;
            p_y     <= '0;
            xmin    <= '0;
            xmax    <= '0;
            ymax    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tri_nd) begin
                        v1_x    <= t1_x;
                        v1_y    <= t1_y;
                        v2_x    <= t2_x;
                        v2_y    <= t2_y;
                        v3_x    <= t3_x;
                        v3_y    <= t3_y;
                        tri_rfd <= 1'b0;
                        busy    <= 1'b1;
                        state   <= BBOX;
                    end
                end
                BBOX: begin
                    if (box_empty) begin
                        done    <= 1'b1;
                        tri_rfd <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        xmin   <= bx_min;
                        xmax   <= bx_max_c;
                        ymax   <= by_max_c;
                        p_x    <= bx_min;
                        p_y    <= by_min;
                        p_last <= (bx_min == bx_max_c) && (by_min == by_max_c);
                        nd     <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        if (p_last) begin
                            nd      <= 1'b0;
                            p_last  <= 1'b0;
                            done    <= 1'b1;
                            tri_rfd <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else if (p_x == xmax) begin
                            p_x    <= xmin;
                            p_y    <= p_y + ONE;
                            p_last <= (xmin == xmax) && ((p_y + ONE) == ymax);
                        end else begin
                            p_x    <= p_x + ONE;
                            p_last <= ((p_x + ONE) == xmax) && (p_y == ymax);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_bbox_scanner.sv
module tb_triangle_bbox_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        tri_nd;
    logic        tri_rfd;
    logic [15:0] t1_x, t1_y, t2_x, t2_y, t3_x, t3_y;
    logic        nd;
    logic        ds_rfd;
    logic [15:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
    logic [15:0] p_x, p_y;
    logic        p_last;
    logic        done;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    triangle_bbox_scanner #(.COORD_W(16), .WIDTH(640), .HEIGHT(480)) dut (
        .clk     (clk),
        .rst     (rst),
        .tri_nd  (tri_nd),
        .tri_rfd (tri_rfd),
        .t1_x    (t1_x),
        .t1_y    (t1_y),
        .t2_x    (t2_x),
        .t2_y    (t2_y),
        .t3_x    (t3_x),
        .t3_y    (t3_y),
        .nd      (nd),
        .ds_rfd  (ds_rfd),
        .v1_x    (v1_x),
        .v1_y    (v1_y),
        .v2_x    (v2_x),
        .v2_y    (v2_y),
        .v3_x    (v3_x),
        .v3_y    (v3_y),
        .p_x     (p_x),
        .p_y     (p_y),
        .p_last  (p_last),
        .done    (done),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offers a triangle at the current negedge (cycle N), returns at the
    // negedge of cycle N+2 after checking the intermediate BBOX cycle.
    task automatic offer(input int ax, ay, bx, by, cx, cy);
        t1_x = 16'(ax); t1_y = 16'(ay);
        t2_x = 16'(bx); t2_y = 16'(by);
        t3_x = 16'(cx); t3_y = 16'(cy);
        tri_nd = 1'b1;
        chk("tri_rfd_at_offer", tri_rfd, 1);
        @(negedge clk);
        tri_nd = 1'b0;
        t1_x = 16'd999; t1_y = 16'd999; t2_x = 16'd999;
        t2_y = 16'd999; t3_x = 16'd999; t3_y = 16'd999;
        chk("tri_rfd_bbox", tri_rfd, 0);
        chk("busy_bbox", busy, 1);
        chk("nd_bbox", nd, 0);
        chk("done_bbox", done, 0);
        @(negedge clk);
        chk("v1_x", v1_x, 32'(ax));
        chk("v1_y", v1_y, 32'(ay));
        chk("v2_x", v2_x, 32'(bx));
        chk("v2_y", v2_y, 32'(by));
        chk("v3_x", v3_x, 32'(cx));
        chk("v3_y", v3_y, 32'(cy));
    endtask

    // Expects the raster walk of [xlo..xhi] x [ylo..yhi], stopping early after
    // max_xfer transfers. With toggle, ds_rfd alternates 1/0 and the stalled
    // cycles re-check the same pixel for stability.
    task automatic scan(input int xlo, xhi, ylo, yhi, input bit toggle, input int max_xfer);
        int ex = xlo;
        int ey = ylo;
        int cnt = 0;
        bit phase = 1'b1;
        while (ey <= yhi && cnt < max_xfer) begin
            ds_rfd = toggle ? phase : 1'b1;
            chk("nd", nd, 1);
            chk("p_x", p_x, 32'(ex));
            chk("p_y", p_y, 32'(ey));
            chk("p_last", p_last, 32'((ex == xhi) && (ey == yhi)));
            chk("done_scan", done, 0);
            chk("tri_rfd_scan", tri_rfd, 0);
            if (ds_rfd) begin
                cnt++;
                if (ex == xhi) begin
                    ex = xlo;
                    ey++;
                end else begin
                    ex++;
                end
            end
            phase = ~phase;
            @(negedge clk);
        end
        ds_rfd = 1'b1;
    endtask

    task automatic check_done_cycle(input string tag);
        chk({tag, "_nd"}, nd, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_tri_rfd"}, tri_rfd, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        tri_nd = 1'b0;
        ds_rfd = 1'b1;
        t1_x = '0; t1_y = '0; t2_x = '0; t2_y = '0; t3_x = '0; t3_y = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_nd", nd, 0);
        chk("rst_p_last", p_last, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tri_rfd", tri_rfd, 1);
        chk("rst_p_x", p_x, 0);
        chk("rst_v1_x", v1_x, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic 3x3 box, full-rate
        offer(2, 1, 4, 1, 2, 3);
        scan(2, 4, 1, 3, 1'b0, 1000);
        check_done_cycle("t1");

        // 2: same triangle accepted in the done cycle, ds_rfd toggling
        offer(2, 1, 4, 1, 2, 3);
        scan(2, 4, 1, 3, 1'b1, 1000);
        check_done_cycle("t2");
        @(negedge clk);
        chk("t2_done_gone", done, 0);

        // 3: box clamped at the bottom-right screen corner
        offer(630, 470, 700, 470, 630, 500);
        scan(630, 639, 470, 479, 1'b0, 1000);
        check_done_cycle("t3");
        @(negedge clk);

        // 4: box entirely right of the screen
        offer(650, 10, 700, 10, 650, 20);
        check_done_cycle("t4");
        @(negedge clk);
        chk("t4_done_gone", done, 0);
        chk("t4_tri_rfd", tri_rfd, 1);

        // 5: degenerate single pixel
        offer(5, 5, 5, 5, 5, 5);
        scan(5, 5, 5, 5, 1'b0, 1000);
        check_done_cycle("t5");
        @(negedge clk);

        // 6: reset after the third transfer, then a fresh small triangle
        offer(2, 1, 4, 1, 2, 3);
        scan(2, 4, 1, 3, 1'b0, 3);
        chk("t6_nd_before_rst", nd, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_nd", nd, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_tri_rfd", tri_rfd, 1);
        @(negedge clk);
        chk("t6_no_done", done, 0);
        chk("t6_nd_idle", nd, 0);
        offer(0, 0, 1, 0, 0, 1);
        scan(0, 1, 0, 1, 1'b0, 1000);
        check_done_cycle("t6");
        @(negedge clk);
        chk("t6_done_gone", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
